bullet_scheduler: RTL and testbench
===================================

BULLET_SCHEDULER -- requirements
Module: bullet_scheduler

Interface
REQ-001 The block SHALL provide parameter NUM_SLOTS, default 5, giving the number of player-bullet slots (range 2..8).
REQ-002 The block SHALL provide parameter COOLDOWN_TICKS, default 8, giving the minimum tick strobes between launches (range 1..255).
REQ-003 The block SHALL provide parameter REPEAT, default 1; 1 = auto-fire while the key is held, 0 = one shot per press.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 The block SHALL have port fire_req, input, 1 bit: level, high while the fire key is down.
REQ-007 The block SHALL have port tick, input, 1 bit: single-cycle frame strobe.
REQ-008 The block SHALL have port slot_busy, input, NUM_SLOTS bits: bit i is high while bullet i is in flight.
REQ-009 The block SHALL have port launch, output, NUM_SLOTS bits: one-hot single-cycle pulse that starts bullet i.
REQ-010 The block SHALL have port launch_idx, output, 3 bits: index of the most recent launch, held until the next launch.
REQ-011 The block SHALL have port all_busy, output, 1 bit: fire requested but no slot is free.
REQ-012 The block SHALL have port cooling, output, 1 bit: high while in state COOL.
REQ-013 The block SHALL have port shot_count, output, 8 bits: total launches since reset.

Function
REQ-014 The FSM SHALL have three states: IDLE, COOL and HOLD, all registered.
REQ-015 A slot SHALL be free when slot_busy[i]==0 and inflight[i]==0.
- inflight[i] is set on the cycle after launch[i] and cleared when slot_busy[i] is seen high.
REQ-016 In IDLE, when fire_req==1 and a slot is free, the block SHALL select the first free index searching upward from ptr, wrapping modulo NUM_SLOTS.
REQ-017 On the cycle after selection, the block SHALL assert launch[sel] for exactly one cycle.
- Same cycle: launch_idx=sel, ptr=(sel+1) mod NUM_SLOTS, shot_count increments, cooldown counter loads COOLDOWN_TICKS, state becomes COOL.
- Latency from fire_req high to launch is 1 cycle.
REQ-018 In IDLE, when fire_req==1 and no slot is free, the block SHALL set all_busy=1 on the next cycle and SHALL NOT launch.
- all_busy clears on the cycle after fire_req drops or a slot frees.
REQ-019 A slot whose slot_busy falls in the same cycle that fire_req is sampled SHALL be treated as free in that cycle.
REQ-020 In COOL, the counter SHALL decrement once per tick.
- When a tick arrives with count==1: next state is IDLE if REPEAT==1, HOLD if REPEAT==0.
- A tick in the load cycle or in IDLE/HOLD is ignored.
REQ-021 Deasserting fire_req during COOL SHALL NOT shorten the cooldown.
REQ-022 HOLD SHALL return to IDLE on the first cycle that fire_req==0.
REQ-023 shot_count SHALL saturate at 255.
REQ-024 launch SHALL never have more than one bit set, and SHALL never be set outside the IDLE->COOL transition.

Reset
REQ-025 While rst==1, the block SHALL force: state=IDLE, ptr=0, inflight=0, counter=0, launch=0, launch_idx=0, all_busy=0, cooling=0, shot_count=0.
REQ-026 rst SHALL take priority over every other event; a launch that would occur in a reset cycle is suppressed.
REQ-027 Asserting rst mid-COOL or in HOLD SHALL abort to IDLE on the next edge.

Verification
REQ-028 Basic launch: defaults, all slots free, fire_req high at cycle 3 -> launch=00001 at cycle 4 only; launch_idx=0, shot_count=1, cooling=1 from cycle 4.
REQ-029 Auto-fire to exhaustion: COOLDOWN_TICKS=2, REPEAT=1, fire_req held, each launched slot_busy held high -> launches on slots 0,1,2,3,4, each 1 cycle after the 2nd tick of the prior cooldown. After that, all_busy=1 and no further launch.
REQ-030 Round-robin: ptr=2 after launching slot 1, slot 0 free, slot 2 busy, slot 3 free -> next launch=01000, launch_idx=3.
REQ-031 Single shot: REPEAT=0, fire_req held for 50 ticks -> exactly one launch. Release for 1 cycle then press -> second launch 1 cycle after the press.
REQ-032 Reset mid-cooldown: rst high 1 cycle during COOL -> cooling=0 and shot_count=0 the next cycle. The next press launches slot 0.
REQ-033 Saturation and simultaneous free: 260 launches -> shot_count=255. A slot_busy fall coincident with fire_req rise -> that slot is launched 1 cycle later.

Source files
------------

// File: rtl/bullet_scheduler.sv
// rtl/bullet_scheduler.sv - player-bullet slot scheduler with cooldown and auto/one-shot fire
module bullet_scheduler #(
    parameter int NUM_SLOTS      = 5,
    parameter int COOLDOWN_TICKS = 8,
    parameter int REPEAT         = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 fire_req,
    input  logic                 tick,
    input  logic [NUM_SLOTS-1:0] slot_busy,
    output logic [NUM_SLOTS-1:0] launch,
    output logic [2:0]           launch_idx,
    output logic                 all_busy,
    output logic                 cooling,
    output logic [7:0]           shot_count
);

    typedef enum logic [1:0] {
        IDLE,
        COOL,
        HOLD
    } state_t;

    state_t               state;
    state_t               state_nx;
    logic [2:0]           ptr;
    logic [2:0]           ptr_nx;
    logic [NUM_SLOTS-1:0] inflight;
    logic [7:0]           count;
    logic [7:0]           free8;
    logic [3:0]           scan_idx;
    logic [2:0]           sel;
    logic                 found;
    logic                 fire_go;
    logic                 busy_nx;

    // A slot is only reusable once its bullet has been seen in flight and then landed.
    always_comb begin
        free8                  = '0;
        free8[NUM_SLOTS-1:0]   = ~slot_busy & ~inflight;
        scan_idx               = '0;
        sel                    = '0;
        found                  = 1'b0;
        for (int k = 0; k < NUM_SLOTS; k++) begin
            scan_idx = {1'b0, ptr} + 4'(k);
            if (scan_idx >= 4'(NUM_SLOTS)) begin
                scan_idx = scan_idx - 4'(NUM_SLOTS);
            end
            if (!found && free8[scan_idx[2:0]]) begin
                found = 1'b1;
                sel   = scan_idx[2:0];
            end
        end
        ptr_nx = (sel == 3'(NUM_SLOTS - 1)) ? 3'd0 : sel + 3'd1;
    end

    always_comb begin
        state_nx = state;
        fire_go  = 1'b0;
        busy_nx  = 1'b0;
        case (state)
            IDLE: begin
                if (fire_req) begin
                    if (found) begin
                        fire_go  = 1'b1;
                        state_nx = COOL;
                    end else begin
                        busy_nx = 1'b1;
                    end
                end
            end
            COOL: begin
                if (tick && count == 8'd1) begin
                    state_nx = (REPEAT == 1) ? IDLE : HOLD;
                end
            end
            HOLD: begin
                if (!fire_req) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr        <= '0;
            inflight   <= '0;
            count      <= '0;
            launch     <= '0;
            launch_idx <= '0;
            all_busy   <= 1'b0;
            shot_count <= '0;
        end else begin
            launch   <= '0;
            all_busy <= busy_nx;
            inflight <= (inflight | launch) & ~slot_busy;
            if (fire_go) begin
                launch     <= {{(NUM_SLOTS-1){1'b0}}, 1'b1} << sel;
                launch_idx <= sel;
                ptr        <= ptr_nx;
                count      <= 8'(COOLDOWN_TICKS);
                if (shot_count != 8'hFF) begin
                    shot_count <= shot_count + 8'd1;
                end
            end else if (state == COOL && tick) begin
                count <= count - 8'd1;
            end
        end
    end

    assign cooling = (state == COOL);

endmodule

// File: tb/tb_bullet_scheduler.sv
// tb/tb_bullet_scheduler.sv - randomized bench for bullet_scheduler against a behavioural model
module tb_bullet_scheduler;

    localparam int N   = 5;
    localparam int CD0 = 2;
    localparam int CD1 = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       fire_req;
    logic       tick;
    logic [4:0] sb       [2];
    logic [4:0] launch_w [2];
    logic [2:0] idx_w    [2];
    logic       allb_w   [2];
    logic       cool_w   [2];
    logic [7:0] shots_w  [2];

    int vectors    = 0;
    int miscompares = 0;

    // unit 0 auto-fires, unit 1 is one-shot-per-press
    logic [4:0] m_launch [2];
    logic [4:0] m_infl   [2];
    int         m_idx    [2];
    int         m_ptr    [2];
    int         m_cool   [2];
    int         m_shots  [2];
    bit         m_hold   [2];
    bit         m_allb   [2];

    int env_mode;
    int dly  [2][5];
    int life [2][5];

    always #5 clk = ~clk;

    bullet_scheduler #(.NUM_SLOTS(N), .COOLDOWN_TICKS(CD0), .REPEAT(1)) dut_a (
        .clk(clk), .rst(rst), .fire_req(fire_req), .tick(tick), .slot_busy(sb[0]),
        .launch(launch_w[0]), .launch_idx(idx_w[0]), .all_busy(allb_w[0]),
        .cooling(cool_w[0]), .shot_count(shots_w[0])
    );

    bullet_scheduler #(.NUM_SLOTS(N), .COOLDOWN_TICKS(CD1), .REPEAT(0)) dut_b (
        .clk(clk), .rst(rst), .fire_req(fire_req), .tick(tick), .slot_busy(sb[1]),
        .launch(launch_w[1]), .launch_idx(idx_w[1]), .all_busy(allb_w[1]),
        .cooling(cool_w[1]), .shot_count(shots_w[1])
    );

    task automatic model_step(input int u);
        logic [4:0] free;
        logic [4:0] prev;
        int         j;
        bit         got;
        if (rst) begin
            m_launch[u] = '0; m_infl[u] = '0; m_idx[u] = 0; m_ptr[u] = 0;
            m_cool[u] = 0; m_shots[u] = 0; m_hold[u] = 0; m_allb[u] = 0;
        end else begin
            prev        = m_launch[u];
            m_launch[u] = '0;
            free        = ~sb[u] & ~m_infl[u];
            for (int i = 0; i < N; i++) begin
                if (sb[u][i]) m_infl[u][i] = 1'b0;
                else if (prev[i]) m_infl[u][i] = 1'b1;
            end
            m_allb[u] = 0;
            if (m_cool[u] > 0) begin
                if (tick) begin
                    m_cool[u]--;
                    if (m_cool[u] == 0 && u == 1) m_hold[u] = 1;
                end
            end else if (m_hold[u]) begin
                if (!fire_req) m_hold[u] = 0;
            end else if (fire_req) begin
                got = 0;
                for (int k = 0; k < N && !got; k++) begin
                    j = (m_ptr[u] + k) % N;
                    if (free[j]) begin
                        got            = 1;
                        m_launch[u][j] = 1'b1;
                        m_idx[u]       = j;
                        m_ptr[u]       = (j + 1) % N;
                        m_cool[u]      = (u == 0) ? CD0 : CD1;
                        if (m_shots[u] < 255) m_shots[u]++;
                    end
                end
                if (!got) m_allb[u] = 1;
            end
        end
    endtask

    task automatic env_update();
        for (int u = 0; u < 2; u++) begin
            for (int i = 0; i < N; i++) begin
                if (env_mode == 1) begin
                    if (m_launch[u][i]) sb[u][i] = 1'b1;
                end else if (env_mode == 2) begin
                    if (m_launch[u][i]) begin
                        dly[u][i]  = $urandom_range(0, 2);
                        life[u][i] = $urandom_range(1, 12);
                    end
                    if (dly[u][i] > 0) dly[u][i]--;
                    else if (life[u][i] > 0) begin
                        sb[u][i] = 1'b1;
                        life[u][i]--;
                    end else sb[u][i] = 1'b0;
                end
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step(0);
        model_step(1);
        #1;
        env_update();
    endtask

    task automatic reset_all();
        rst = 1'b1; fire_req = 1'b0; tick = 1'b0; env_mode = 0;
        sb[0] = '0; sb[1] = '0;
        for (int u = 0; u < 2; u++)
            for (int i = 0; i < N; i++) begin
                dly[u][i] = 0; life[u][i] = 0;
            end
        cycle();
        cycle();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0; fire_req = 1'b1; tick = 1'b0; env_mode = 0; sb[0] = '0; sb[1] = '0;
        for (int c = 0; c < 3; c++) cycle();
        reset_all();
        for (int u = 0; u < 2; u++) begin
            vectors++;
            if (launch_w[u] !== 5'b0 || idx_w[u] !== 3'd0 || allb_w[u] !== 1'b0 ||
                cool_w[u] !== 1'b0 || shots_w[u] !== 8'd0) begin
                miscompares++;
                $display("FAIL reset u%0d got launch=%b idx=%0d all_busy=%b cooling=%b shots=%0d exp all zero",
                         u, launch_w[u], idx_w[u], allb_w[u], cool_w[u], shots_w[u]);
            end
        end
    endtask

    task automatic test_basic_launch();
        reset_all();
        for (int c = 0; c < 3; c++) cycle();
        fire_req = 1'b1;
        cycle();
        vectors++;
        if (launch_w[0] !== 5'b00001) begin
            miscompares++;
            $display("FAIL basic_launch got %b exp 00001", launch_w[0]);
        end
        cycle();
        vectors++;
        if (launch_w[0] !== 5'b0 || idx_w[0] !== 3'd0 || shots_w[0] !== 8'd1 || cool_w[0] !== 1'b1) begin
            miscompares++;
            $display("FAIL basic_after got launch=%b idx=%0d shots=%0d cooling=%b exp 00000 0 1 1",
                     launch_w[0], idx_w[0], shots_w[0], cool_w[0]);
        end
        fire_req = 1'b0;
    endtask

    task automatic test_autofire();
        int got_q[$];
        reset_all();
        env_mode = 1;
        fire_req = 1'b1;
        for (int c = 0; c < 80; c++) begin
            tick = (c % 4 == 3);
            cycle();
            vectors++;
            if (launch_w[0] !== m_launch[0]) begin
                miscompares++;
                $display("FAIL autofire_launch cyc %0d got %b exp %b", c, launch_w[0], m_launch[0]);
            end
            if (launch_w[0] != 5'b0) got_q.push_back(int'(idx_w[0]));
        end
        tick = 1'b0;
        vectors++;
        if (got_q.size() != 5) begin
            miscompares++;
            $display("FAIL autofire_count got %0d exp 5", got_q.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                vectors++;
                if (got_q[i] != i) begin
                    miscompares++;
                    $display("FAIL autofire_order #%0d got %0d exp %0d", i, got_q[i], i);
                end
            end
        end
        vectors++;
        if (allb_w[0] !== 1'b1) begin
            miscompares++;
            $display("FAIL autofire_all_busy got %b exp 1", allb_w[0]);
        end
        fire_req = 1'b0;
    endtask

    task automatic test_round_robin();
        int n = 0;
        reset_all();
        env_mode = 1;
        fire_req = 1'b1;
        for (int c = 0; c < 60 && n < 2; c++) begin
            tick = (c % 2 == 1);
            cycle();
            if (m_launch[0] != 5'b0) n++;
        end
        fire_req = 1'b0;
        env_mode = 0;
        sb[0] = 5'b00110;
        tick = 1'b1;
        for (int c = 0; c < 20 && m_cool[0] > 0; c++) cycle();
        tick = 1'b0;
        vectors++;
        if (n != 2 || cool_w[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL rr_setup got launches=%0d cooling=%b exp 2 0", n, cool_w[0]);
        end
        fire_req = 1'b1;
        cycle();
        vectors++;
        if (launch_w[0] !== 5'b01000 || idx_w[0] !== 3'd3) begin
            miscompares++;
            $display("FAIL round_robin got launch=%b idx=%0d exp 01000 3", launch_w[0], idx_w[0]);
        end
        fire_req = 1'b0;
    endtask

    task automatic test_single_shot();
        int nl = 0;
        reset_all();
        env_mode = 2;
        fire_req = 1'b1;
        for (int c = 0; c < 100; c++) begin
            tick = (c % 2 == 0);
            cycle();
            if (launch_w[1] != 5'b0) nl++;
        end
        tick = 1'b0;
        vectors++;
        if (nl != 1 || cool_w[1] !== 1'b0) begin
            miscompares++;
            $display("FAIL single_shot got launches=%0d cooling=%b exp 1 0", nl, cool_w[1]);
        end
        fire_req = 1'b0;
        cycle();
        fire_req = 1'b1;
        cycle();
        vectors++;
        if (launch_w[1] !== 5'b00010 || idx_w[1] !== 3'd1 || shots_w[1] !== 8'd2) begin
            miscompares++;
            $display("FAIL repress got launch=%b idx=%0d shots=%0d exp 00010 1 2",
                     launch_w[1], idx_w[1], shots_w[1]);
        end
        fire_req = 1'b0;
    endtask

    task automatic test_reset_mid_cool();
        reset_all();
        fire_req = 1'b1;
        cycle();
        fire_req = 1'b0;
        cycle();
        vectors++;
        if (cool_w[0] !== 1'b1) begin
            miscompares++;
            $display("FAIL midcool_pre got cooling=%b exp 1", cool_w[0]);
        end
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        vectors++;
        if (cool_w[0] !== 1'b0 || shots_w[0] !== 8'd0 || cool_w[1] !== 1'b0) begin
            miscompares++;
            $display("FAIL midcool_reset got cooling=%b shots=%0d exp 0 0", cool_w[0], shots_w[0]);
        end
        fire_req = 1'b1;
        cycle();
        vectors++;
        if (launch_w[0] !== 5'b00001) begin
            miscompares++;
            $display("FAIL midcool_relaunch got %b exp 00001", launch_w[0]);
        end
        fire_req = 1'b0;
    endtask

    task automatic test_saturation();
        int nl = 0;
        reset_all();
        env_mode = 2;
        fire_req = 1'b1;
        tick = 1'b1;
        for (int c = 0; c < 4000 && nl < 260; c++) begin
            cycle();
            if (launch_w[0] != 5'b0) nl++;
        end
        vectors++;
        if (nl != 260 || shots_w[0] !== 8'd255) begin
            miscompares++;
            $display("FAIL saturation got launches=%0d shots=%0d exp 260 255", nl, shots_w[0]);
        end
        env_mode = 0;
        fire_req = 1'b0;
        sb[0] = 5'b11111;
        sb[1] = 5'b11111;
        for (int c = 0; c < 10; c++) cycle();
        sb[0] = 5'b11011;
        fire_req = 1'b1;
        tick = 1'b0;
        cycle();
        vectors++;
        if (launch_w[0] !== 5'b00100 || shots_w[0] !== 8'd255) begin
            miscompares++;
            $display("FAIL coincident_free got launch=%b shots=%0d exp 00100 255", launch_w[0], shots_w[0]);
        end
        fire_req = 1'b0;
    endtask

    task automatic test_random();
        logic e_cool;
        reset_all();
        env_mode = 2;
        for (int c = 0; c < 2000; c++) begin
            if ($urandom_range(0, 7) == 0) fire_req = ~fire_req;
            tick = ($urandom_range(0, 2) == 0);
            rst  = ($urandom_range(0, 199) == 0);
            cycle();
            for (int u = 0; u < 2; u++) begin
                e_cool = (m_cool[u] > 0);
                vectors++;
                if (launch_w[u] !== m_launch[u] || idx_w[u] !== 3'(m_idx[u]) ||
                    allb_w[u] !== m_allb[u] || cool_w[u] !== e_cool ||
                    shots_w[u] !== 8'(m_shots[u])) begin
                    miscompares++;
                    $display("FAIL random u%0d cyc %0d got l=%b i=%0d ab=%b co=%b s=%0d exp l=%b i=%0d ab=%b co=%b s=%0d",
                             u, c, launch_w[u], idx_w[u], allb_w[u], cool_w[u], shots_w[u],
                             m_launch[u], m_idx[u], m_allb[u], e_cool, m_shots[u]);
                end
            end
        end
        rst = 1'b0;
        fire_req = 1'b0;
    endtask

    initial begin
        rst = 1'b1; fire_req = 1'b0; tick = 1'b0; env_mode = 0;
        sb[0] = '0; sb[1] = '0;
        for (int u = 0; u < 2; u++) begin
            m_launch[u] = '0; m_infl[u] = '0; m_idx[u] = 0; m_ptr[u] = 0;
            m_cool[u] = 0; m_shots[u] = 0; m_hold[u] = 0; m_allb[u] = 0;
        end
        test_reset();
        test_basic_launch();
        test_autofire();
        test_round_robin();
        test_single_shot();
        test_reset_mid_cool();
        test_saturation();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
